// File: rtl/numa_bank_adapter.sv
// rtl/numa_bank_adapter.sv - bank-side adapter: credit-gated grant, tag pipeline, response FIFO with bypass
module numa_bank_adapter #(
    parameter int NumIn         = 4,
    parameter int ReqDataWidth  = 32,
    parameter int RespDataWidth = 32,
    parameter int MemLatency    = 1,
    parameter int RespFifoDepth = 2,
    parameter int IdxWidth      = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic [IdxWidth-1:0]      idx_i,
    input  logic [ReqDataWidth-1:0]  wdata_i,
    output logic                     vld_o,
    input  logic                     rdy_i,
    output logic [IdxWidth-1:0]      idx_o,
    output logic [RespDataWidth-1:0] rdata_o,
    output logic                     mem_req_o,
    output logic [ReqDataWidth-1:0]  mem_wdata_o,
    input  logic [RespDataWidth-1:0] mem_rdata_i
);

    localparam int CntW = $clog2(RespFifoDepth + 1);
    localparam int PtrW = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
    localparam logic [CntW-1:0] DepthC = CntW'(RespFifoDepth);

    logic [CntW-1:0]          outstanding;
    logic                     resp_pop;

    logic [MemLatency-1:0]    pipe_vld;
    logic [IdxWidth-1:0]      pipe_idx [MemLatency];
    logic                     head_vld;
    logic [IdxWidth-1:0]      head_idx;

    logic [IdxWidth-1:0]      fifo_idx  [RespFifoDepth];
    logic [RespDataWidth-1:0] fifo_data [RespFifoDepth];
    logic [PtrW-1:0]          rd_ptr;
    logic [PtrW-1:0]          wr_ptr;
    logic [CntW-1:0]          fifo_cnt;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     push;
    logic                     pop_fifo;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespFifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grant depends only on the registered credit count, never on rdy_i.
    assign gnt_o       = req_i & rst_ni & (outstanding < DepthC);
    assign mem_req_o   = req_i & gnt_o;
    assign mem_wdata_o = wdata_i;

    assign resp_pop = vld_o & rdy_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
        end else if (gnt_o && !resp_pop) begin
            outstanding <= outstanding + 1'b1;
        end else if (!gnt_o && resp_pop) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld <= '0;
            for (int i = 0; i < MemLatency; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= gnt_o;
            pipe_idx[0] <= idx_i;
            for (int i = 1; i < MemLatency; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    assign head_vld = pipe_vld[MemLatency-1];
    assign head_idx = pipe_idx[MemLatency-1];

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DepthC);
    // Bypass only when nothing is queued ahead and the crossbar takes it now.
    assign push       = head_vld & (~fifo_empty | ~rdy_i);
    assign pop_fifo   = ~fifo_empty & rdy_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_fifo) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop_fifo) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (!push && pop_fifo) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_idx[wr_ptr]  <= head_idx;
            fifo_data[wr_ptr] <= mem_rdata_i;
        end
    end

    always_comb begin
        vld_o   = 1'b0;
        idx_o   = '0;
        rdata_o = '0;
        if (!fifo_empty) begin
            vld_o   = 1'b1;
            idx_o   = fifo_idx[rd_ptr];
            rdata_o = fifo_data[rd_ptr];
        end else if (head_vld) begin
            vld_o   = 1'b1;
            idx_o   = head_idx;
            rdata_o = mem_rdata_i;
        end
    end

    a_mem_latency: assert property (@(posedge clk_i) MemLatency >= 1);
    a_fifo_depth:  assert property (@(posedge clk_i) RespFifoDepth >= 1);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));
    a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (vld_o && !rdy_i) |=> (vld_o && $stable(idx_o) && $stable(rdata_o)));

endmodule

// File: tb/tb_numa_bank_adapter.sv
// tb/tb_numa_bank_adapter.sv - directed-vector bench for numa_bank_adapter over three configurations
module tb_numa_bank_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    // A: MemLatency=1, Depth=2
    logic        a_req, a_gnt, a_vld, a_rdy, a_mem_req;
    logic [1:0]  a_idx, a_idx_o;
    logic [31:0] a_wdata, a_rdata, a_mem_wdata, a_mem_rdata, a_d1;
    // B: MemLatency=2, Depth=3
    logic        b_req, b_gnt, b_vld, b_rdy, b_mem_req;
    logic [1:0]  b_idx, b_idx_o;
    logic [31:0] b_wdata, b_rdata, b_mem_wdata, b_mem_rdata, b_d1, b_d2;
    // C: MemLatency=2, Depth=1
    logic        c_req, c_gnt, c_vld, c_rdy, c_mem_req;
    logic [1:0]  c_idx, c_idx_o;
    logic [31:0] c_wdata, c_rdata, c_mem_wdata, c_mem_rdata, c_d1, c_d2;

    // Bank models: read data is the request payload delayed by the latency.
    always @(posedge clk) begin
        a_d1 <= a_wdata;
        b_d1 <= b_wdata;
        b_d2 <= b_d1;
        c_d1 <= c_wdata;
        c_d2 <= c_d1;
    end
    assign a_mem_rdata = a_d1;
    assign b_mem_rdata = b_d2;
    assign c_mem_rdata = c_d2;

    numa_bank_adapter #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32),
                        .MemLatency(1), .RespFifoDepth(2)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .gnt_o(a_gnt), .idx_i(a_idx),
        .wdata_i(a_wdata), .vld_o(a_vld), .rdy_i(a_rdy), .idx_o(a_idx_o), .rdata_o(a_rdata),
        .mem_req_o(a_mem_req), .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata));

    numa_bank_adapter #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32),
                        .MemLatency(2), .RespFifoDepth(3)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .gnt_o(b_gnt), .idx_i(b_idx),
        .wdata_i(b_wdata), .vld_o(b_vld), .rdy_i(b_rdy), .idx_o(b_idx_o), .rdata_o(b_rdata),
        .mem_req_o(b_mem_req), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata));

    numa_bank_adapter #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32),
                        .MemLatency(2), .RespFifoDepth(1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(c_req), .gnt_o(c_gnt), .idx_i(c_idx),
        .wdata_i(c_wdata), .vld_o(c_vld), .rdy_i(c_rdy), .idx_o(c_idx_o), .rdata_o(c_rdata),
        .mem_req_o(c_mem_req), .mem_wdata_o(c_mem_wdata), .mem_rdata_i(c_mem_rdata));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Single read (A)
    localparam bit          T1_REQ [3] = '{1, 0, 0};
    localparam bit          T1_GNT [3] = '{1, 0, 0};
    localparam bit          T1_VLD [3] = '{0, 1, 0};
    localparam logic [1:0]  T1_IDX [3] = '{0, 3, 0};
    localparam logic [31:0] T1_DAT [3] = '{0, 32'hCAFE0001, 0};

    // Backpressure then drain (A)
    localparam bit          T3_GNT [10] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
    localparam bit          T3_VLD [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    localparam logic [1:0]  T3_IDX [10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    localparam logic [31:0] T3_DAT [10] = '{0, 32'h2000, 32'h2000, 32'h2000, 32'h2000,
                                            32'h2000, 32'h2001, 32'h2006, 32'h2007, 0};

    // Pop from FIFO while a head arrives at full credit (A)
    localparam bit          T4_REQ [6] = '{1, 1, 1, 1, 0, 0};
    localparam bit          T4_RDY [6] = '{0, 0, 1, 1, 1, 1};
    localparam bit          T4_GNT [6] = '{1, 1, 0, 1, 0, 0};
    localparam bit          T4_VLD [6] = '{0, 1, 1, 1, 1, 0};
    localparam logic [1:0]  T4_IDX [6] = '{0, 1, 1, 2, 0, 0};
    localparam logic [31:0] T4_DAT [6] = '{0, 32'h3000, 32'h3000, 32'h3001, 32'h3003, 0};

    // Reset mid-flight (A)
    localparam bit          T6_RST [6] = '{1, 1, 0, 1, 1, 1};
    localparam bit          T6_REQ [6] = '{1, 1, 1, 1, 0, 0};
    localparam logic [1:0]  T6_IIN [6] = '{1, 2, 0, 3, 0, 0};
    localparam logic [31:0] T6_WIN [6] = '{32'h5000, 32'h5001, 32'h5002, 32'h5003, 0, 0};
    localparam bit          T6_RDY [6] = '{0, 0, 0, 1, 1, 1};
    localparam bit          T6_GNT [6] = '{1, 1, 0, 1, 0, 0};
    localparam bit          T6_VLD [6] = '{0, 1, 0, 0, 1, 0};
    localparam logic [1:0]  T6_IDX [6] = '{0, 1, 0, 0, 3, 0};
    localparam logic [31:0] T6_DAT [6] = '{0, 32'h5000, 0, 0, 32'h5003, 0};

    initial begin
        rst_n = 1'b0;
        a_req = 1'b1; a_idx = 2'd1; a_wdata = 32'hDEAD0000; a_rdy = 1'b1;
        b_req = 1'b1; b_idx = 2'd1; b_wdata = 32'hDEAD0001; b_rdy = 1'b1;
        c_req = 1'b1; c_idx = 2'd1; c_wdata = 32'hDEAD0002; c_rdy = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst a gnt", a_gnt, 0);
        check("rst a mem_req", a_mem_req, 0);
        check("rst a vld", a_vld, 0);
        check("rst a idx", a_idx_o, 0);
        check("rst a rdata", a_rdata, 0);
        check("rst b gnt", b_gnt, 0);
        check("rst b vld", b_vld, 0);
        check("rst c gnt", c_gnt, 0);
        check("rst c vld", c_vld, 0);
        next_cycle();
        a_req = 1'b0; b_req = 1'b0; c_req = 1'b0;
        a_wdata = '0; b_wdata = '0; c_wdata = '0;
        rst_n = 1'b1;
        next_cycle();

        for (int c = 0; c < 3; c++) begin
            a_req = T1_REQ[c]; a_idx = 2'd3; a_rdy = 1'b1;
            a_wdata = T1_REQ[c] ? 32'hCAFE0001 : 32'h0;
            @(negedge clk);
            check($sformatf("single gnt c%0d", c), a_gnt, T1_GNT[c]);
            check($sformatf("single mem_req c%0d", c), a_mem_req, T1_GNT[c]);
            check($sformatf("single vld c%0d", c), a_vld, T1_VLD[c]);
            check($sformatf("single idx c%0d", c), a_idx_o, T1_IDX[c]);
            check($sformatf("single rdata c%0d", c), a_rdata, T1_DAT[c]);
            if (c == 0) check("single mem_wdata", a_mem_wdata, 32'hCAFE0001);
            next_cycle();
        end

        for (int c = 0; c < 11; c++) begin
            b_req = (c < 8); b_idx = 2'(c % 4); b_rdy = 1'b1;
            b_wdata = (c < 8) ? 32'h1000 + 32'(c) : 32'h0;
            @(negedge clk);
            check($sformatf("stream gnt c%0d", c), b_gnt, (c < 8) ? 1 : 0);
            check($sformatf("stream vld c%0d", c), b_vld, (c >= 2 && c <= 9) ? 1 : 0);
            check($sformatf("stream idx c%0d", c), b_idx_o,
                  (c >= 2 && c <= 9) ? 32'((c - 2) % 4) : 0);
            check($sformatf("stream rdata c%0d", c), b_rdata,
                  (c >= 2 && c <= 9) ? 32'h1000 + 32'(c - 2) : 0);
            next_cycle();
        end
        b_req = 1'b0;

        for (int c = 0; c < 10; c++) begin
            a_req = (c < 8); a_idx = 2'(c % 4); a_rdy = (c >= 5);
            a_wdata = (c < 8) ? 32'h2000 + 32'(c) : 32'h0;
            @(negedge clk);
            check($sformatf("bp gnt c%0d", c), a_gnt, T3_GNT[c]);
            check($sformatf("bp vld c%0d", c), a_vld, T3_VLD[c]);
            check($sformatf("bp idx c%0d", c), a_idx_o, T3_IDX[c]);
            check($sformatf("bp rdata c%0d", c), a_rdata, T3_DAT[c]);
            next_cycle();
        end

        for (int c = 0; c < 6; c++) begin
            a_req = T4_REQ[c]; a_idx = 2'((c + 1) % 4); a_rdy = T4_RDY[c];
            a_wdata = T4_REQ[c] ? 32'h3000 + 32'(c) : 32'h0;
            @(negedge clk);
            check($sformatf("pushpop gnt c%0d", c), a_gnt, T4_GNT[c]);
            check($sformatf("pushpop vld c%0d", c), a_vld, T4_VLD[c]);
            check($sformatf("pushpop idx c%0d", c), a_idx_o, T4_IDX[c]);
            check($sformatf("pushpop rdata c%0d", c), a_rdata, T4_DAT[c]);
            next_cycle();
        end

        for (int c = 0; c < 10; c++) begin
            c_req = (c < 9); c_idx = 2'(c % 4); c_rdy = 1'b1;
            c_wdata = (c < 9) ? 32'h4000 + 32'(c) : 32'h0;
            @(negedge clk);
            check($sformatf("throttle gnt c%0d", c), c_gnt, (c < 9 && c % 3 == 0) ? 1 : 0);
            check($sformatf("throttle vld c%0d", c), c_vld, (c % 3 == 2) ? 1 : 0);
            check($sformatf("throttle idx c%0d", c), c_idx_o, (c % 3 == 2) ? 32'((c - 2) % 4) : 0);
            check($sformatf("throttle rdata c%0d", c), c_rdata,
                  (c % 3 == 2) ? 32'h4000 + 32'(c - 2) : 0);
            next_cycle();
        end
        c_req = 1'b0;

        for (int c = 0; c < 6; c++) begin
            rst_n = T6_RST[c];
            a_req = T6_REQ[c]; a_idx = T6_IIN[c]; a_wdata = T6_WIN[c]; a_rdy = T6_RDY[c];
            @(negedge clk);
            check($sformatf("rstflight gnt c%0d", c), a_gnt, T6_GNT[c]);
            check($sformatf("rstflight vld c%0d", c), a_vld, T6_VLD[c]);
            check($sformatf("rstflight idx c%0d", c), a_idx_o, T6_IDX[c]);
            check($sformatf("rstflight rdata c%0d", c), a_rdata, T6_DAT[c]);
            next_cycle();
        end
        @(negedge clk);
        check("rstflight tail vld", a_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
